// File: rtl/vga_pkg.sv
// Shared constants for the tile video subsystem (tile_vram, vga_controller).
package vga_pkg;

    // Tile map geometry: 25 x 18 tiles, 2 bits per tile, 16 tiles per word.
    localparam int TILES_H     = 25;
    localparam int TILES_V     = 18;
    localparam int TILES_TOTAL = TILES_H * TILES_V;
    localparam int VRAM_WORDS  = (TILES_TOTAL + 15) / 16;

    // CPU-visible register offsets (byte addresses).
    localparam logic [8:0] OFF_TILE   = 9'h100;
    localparam logic [8:0] OFF_FILL   = 9'h104;
    localparam logic [8:0] OFF_STATUS = 9'h108;

    // Write-side sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2,
        FILL   = 2'd3
    } vram_state_t;

endpackage

// File: rtl/vram_dp.sv
// Tile RAM: one byte-enabled write port, two registered read ports.
// A read that hits the word being written in the same cycle returns the old word.
module vram_dp #(
    parameter int WORDS = vga_pkg::VRAM_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic [4:0]  bus_raddr,
    output logic [31:0] bus_rdata,
    input  logic [4:0]  disp_raddr,
    output logic [31:0] disp_rdata
);

    localparam logic [5:0] WORDS6 = 6'(WORDS);

    logic [31:0] mem [WORDS];

    logic waddr_ok;
    logic bus_raddr_ok;
    logic disp_raddr_ok;

    assign waddr_ok      = {1'b0, waddr}      < WORDS6;
    assign bus_raddr_ok  = {1'b0, bus_raddr}  < WORDS6;
    assign disp_raddr_ok = {1'b0, disp_raddr} < WORDS6;

    // Byte-enabled write of the storage array.
    // NOTE: the array has no reset; contents survive rst_n and only the read registers clear.
    always_ff @(posedge clk) begin
        if (we && waddr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered reads for the bus and display ports; out-of-range words read as zero.
    // NOTE: non-blocking assignment samples mem before this edge's write lands, giving read-old-data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_rdata  <= '0;
            disp_rdata <= '0;
        end else begin
            bus_rdata  <= bus_raddr_ok  ? mem[bus_raddr]  : 32'd0;
            disp_rdata <= disp_raddr_ok ? mem[disp_raddr] : 32'd0;
        end
    end

endmodule

// File: rtl/tile_vram.sv
// Tile map VRAM: CPU bus with word window and TILE/FILL/STATUS registers,
// plus a never-stalling display read port.
module tile_vram #(
    parameter int TILES_H = vga_pkg::TILES_H,
    parameter int TILES_V = vga_pkg::TILES_V
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_valid,
    output logic        bus_ready,
    input  logic        bus_we,
    input  logic [8:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_wstrb,
    output logic [31:0] bus_rdata,
    output logic        bus_rvalid,
    input  logic [4:0]  disp_addr,
    output logic [31:0] disp_data
);

    localparam int         VRAM_WORDS = (TILES_H * TILES_V + 15) / 16;
    localparam logic [8:0] TOTAL9     = 9'(TILES_H * TILES_V);
    localparam logic [5:0] WORDS6     = 6'(VRAM_WORDS);
    localparam logic [4:0] LAST5      = 5'(VRAM_WORDS - 1);

    vga_pkg::vram_state_t state;

    logic [4:0]  fill_cnt;
    logic [1:0]  fill_colour;
    logic [4:0]  rmw_word;
    logic [4:0]  rmw_pos;
    logic [1:0]  rmw_colour;
    logic        rd_win;

    logic        accept;
    logic        is_win;
    logic        is_tile;
    logic        is_fill;
    logic [4:0]  bus_idx;
    logic        idx_ok;
    logic        tile_ok;

    logic        ram_we;
    logic [4:0]  ram_waddr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wstrb;
    logic [4:0]  ram_bus_raddr;
    logic [31:0] ram_bus_q;
    logic [31:0] rmw_merged;

    // Byte offset within a word carries no meaning on this bus.
    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, bus_addr[1:0]};

    assign accept  = bus_valid && bus_ready;
    assign is_win  = !bus_addr[8];
    assign is_tile = bus_addr == vga_pkg::OFF_TILE;
    assign is_fill = bus_addr == vga_pkg::OFF_FILL;
    assign bus_idx = bus_addr[6:2];
    assign idx_ok  = {1'b0, bus_idx} < WORDS6;
    assign tile_ok = bus_wdata[8:0] < TOTAL9;

    // Replace only the two target bits of the word read in RMW_RD.
    assign rmw_merged = (ram_bus_q & ~(32'h3 << rmw_pos)) | ({30'd0, rmw_colour} << rmw_pos);

    // RMW_RD needs the target word on the bus read port; otherwise it follows the bus index.
    assign ram_bus_raddr = (state == vga_pkg::RMW_RD) ? rmw_word : bus_idx;

    // Window reads return the RAM word; STATUS, TILE, FILL and unmapped reads return zero.
    assign bus_rdata = rd_win ? ram_bus_q : 32'd0;

    // Single write port shared by window writes, RMW write-back and fill.
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = bus_idx;
        ram_wdata = bus_wdata;
        ram_wstrb = bus_wstrb;
        case (state)
            vga_pkg::IDLE: begin
                ram_we = accept && bus_we && is_win && idx_ok;
            end
            vga_pkg::RMW_WR: begin
                ram_we    = 1'b1;
                ram_waddr = rmw_word;
                ram_wdata = rmw_merged;
                ram_wstrb = 4'hF;
            end
            vga_pkg::FILL: begin
                ram_we    = 1'b1;
                ram_waddr = fill_cnt;
                ram_wdata = {16{fill_colour}};
                ram_wstrb = 4'hF;
            end
            default: ;
        endcase
    end

    // Sequencer: accepts requests in IDLE, runs tile RMW and fill, drives registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= vga_pkg::IDLE;
            bus_ready   <= 1'b1;
            bus_rvalid  <= 1'b0;
            rd_win      <= 1'b0;
            fill_cnt    <= '0;
            fill_colour <= '0;
            rmw_word    <= '0;
            rmw_pos     <= '0;
            rmw_colour  <= '0;
        end else begin
            bus_rvalid <= accept && !bus_we;
            rd_win     <= accept && !bus_we && is_win;
            case (state)
                vga_pkg::IDLE: begin
                    if (accept && bus_we && is_tile && tile_ok) begin
                        rmw_word   <= bus_wdata[8:4];
                        rmw_pos    <= {bus_wdata[3:0], 1'b0};
                        rmw_colour <= bus_wdata[17:16];
                        state      <= vga_pkg::RMW_RD;
                        bus_ready  <= 1'b0;
                    end else if (accept && bus_we && is_fill) begin
                        fill_colour <= bus_wdata[1:0];
                        fill_cnt    <= '0;
                        state       <= vga_pkg::FILL;
                        bus_ready   <= 1'b0;
                    end
                end
                vga_pkg::RMW_RD: begin
                    state <= vga_pkg::RMW_WR;
                end
                vga_pkg::RMW_WR: begin
                    state     <= vga_pkg::IDLE;
                    bus_ready <= 1'b1;
                end
                vga_pkg::FILL: begin
                    if (fill_cnt == LAST5) begin
                        fill_cnt  <= '0;
                        state     <= vga_pkg::IDLE;
                        bus_ready <= 1'b1;
                    end else begin
                        fill_cnt <= fill_cnt + 5'd1;
                    end
                end
                default: begin
                    state     <= vga_pkg::IDLE;
                    bus_ready <= 1'b1;
                end
            endcase
        end
    end

    vram_dp #(
        .WORDS(VRAM_WORDS)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (ram_we),
        .waddr     (ram_waddr),
        .wdata     (ram_wdata),
        .wstrb     (ram_wstrb),
        .bus_raddr (ram_bus_raddr),
        .bus_rdata (ram_bus_q),
        .disp_raddr(disp_addr),
        .disp_rdata(disp_data)
    );

endmodule

// File: tb/tb_tile_vram.sv
// Directed self-checking bench for tile_vram.
module tb_tile_vram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [8:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic [4:0]  disp_addr;
    logic [31:0] disp_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tile_vram dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wstrb (bus_wstrb),
        .bus_rdata (bus_rdata),
        .bus_rvalid(bus_rvalid),
        .disp_addr (disp_addr),
        .disp_data (disp_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a write and hold it until accepted; returns #1 after the accepting edge.
    task automatic bus_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
        int guard = 0;
        @(negedge clk);
        bus_valid = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d; bus_wstrb = s;
        while (!bus_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("write_accept_timeout", 32'(guard), 32'd0);
        @(posedge clk);
        #1;
        bus_valid = 1'b0; bus_we = 1'b0;
    endtask

    // Read with rvalid timing captured as {before accept, 1 cycle after, 2 cycles after}.
    task automatic bus_read(input logic [8:0] a, output logic [31:0] d, output logic [2:0] rv);
        int guard = 0;
        @(negedge clk);
        bus_valid = 1'b1; bus_we = 1'b0; bus_addr = a;
        while (!bus_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("read_accept_timeout", 32'(guard), 32'd0);
        rv[2] = bus_rvalid;
        @(posedge clk);
        #1;
        rv[1] = bus_rvalid;
        d = bus_rdata;
        bus_valid = 1'b0;
        @(posedge clk);
        #1;
        rv[0] = bus_rvalid;
    endtask

    // Count cycles with bus_ready low, starting right after an accepted write.
    task automatic count_busy(output int n);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (bus_ready) break;
            n++;
        end
    endtask

    task automatic disp_read(input logic [4:0] idx, output logic [31:0] d);
        @(negedge clk);
        disp_addr = idx;
        @(posedge clk);
        #1;
        d = disp_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [2:0]  rv;
        int          busy;
        int          bad;

        rst_n = 1'b0; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0;
        bus_wdata = '0; bus_wstrb = '0; disp_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready",  32'(bus_ready),  32'd1);
        check("reset_rvalid", 32'(bus_rvalid), 32'd0);
        check("reset_rdata",  bus_rdata,       32'd0);
        check("reset_disp",   disp_data,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Establish a known all-zero map.
        bus_write(9'h104, 32'h0, 4'hF);
        count_busy(busy);
        check("fill0_busy", 32'(busy), 32'd29);

        // Tile 17, colour 2 -> word 1 bits [3:2] = 2.
        bus_write(9'h100, 32'h0002_0011, 4'hF);
        count_busy(busy);
        check("tile17_busy", 32'(busy), 32'd2);
        bus_read(9'h004, d, rv);
        check("tile17_word1", d, 32'h0000_0008);
        check("tile17_rv", 32'(rv), 32'b010);

        // Partial word write: low two bytes only.
        bus_write(9'h004, 32'hDEAD_BEEF, 4'b0011);
        check("wr_no_busy", 32'(bus_ready), 32'd1);
        bus_read(9'h004, d, rv);
        check("strb_rdata", d, 32'h0000_BEEF);
        check("strb_rv", 32'(rv), 32'b010);

        // Display read colliding with a bus write to the same word.
        @(negedge clk);
        disp_addr = 5'd1;
        bus_write(9'h004, 32'h1234_5678, 4'hF);
        check("collide_old", disp_data, 32'h0000_BEEF);
        @(posedge clk);
        #1;
        check("collide_new", disp_data, 32'h1234_5678);

        // Window indices past the last word: writes dropped, reads zero with rvalid.
        bus_write(9'h074, 32'hFFFF_FFFF, 4'hF);
        bus_read(9'h074, d, rv);
        check("oob29_rdata", d, 32'h0);
        check("oob29_rv", 32'(rv), 32'b010);
        bus_write(9'h078, 32'hAAAA_AAAA, 4'hF);
        bus_read(9'h078, d, rv);
        check("oob30_rdata", d, 32'h0);
        disp_read(5'd29, d);
        check("disp_oob29", d, 32'h0);

        // Tile 450 is out of range; tile 449 is the last tile (word 28, bits [3:2]).
        bus_write(9'h100, 32'h0003_01C2, 4'hF);
        count_busy(busy);
        check("tile450_busy", 32'(busy), 32'd0);
        disp_read(5'd28, d);
        check("tile450_word28", d, 32'h0);
        bus_write(9'h100, 32'h0001_01C1, 4'hF);
        count_busy(busy);
        check("tile449_busy", 32'(busy), 32'd2);
        disp_read(5'd28, d);
        check("tile449_word28", d, 32'h0000_0004);

        // Unmapped and write-only register reads.
        bus_write(9'h10C, 32'h5A5A_5A5A, 4'hF);
        check("unmapped_no_busy", 32'(bus_ready), 32'd1);
        bus_read(9'h10C, d, rv);
        check("unmapped_rdata", d, 32'h0);
        check("unmapped_rv", 32'(rv), 32'b010);
        bus_read(9'h100, d, rv);
        check("tile_reg_rdata", d, 32'h0);
        bus_read(9'h104, d, rv);
        check("fill_reg_rdata", d, 32'h0);

        // Fill with colour 3.
        bus_write(9'h104, 32'h0000_0003, 4'hF);
        count_busy(busy);
        check("fill3_busy", 32'(busy), 32'd29);
        bad = 0;
        for (int i = 0; i < 29; i++) begin
            disp_read(5'(i), d);
            if (d !== 32'hFFFF_FFFF) bad++;
        end
        check("fill3_words_bad", 32'(bad), 32'd0);
        bus_read(9'h108, d, rv);
        check("status_idle", d, 32'h0);
        check("status_rv", 32'(rv), 32'b010);
        bus_read(9'h070, d, rv);
        check("fill3_word28_bus", d, 32'hFFFF_FFFF);

        // Fill with colour 1, aborted by reset during fill cycle 10.
        bus_write(9'h104, 32'h0000_0001, 4'hF);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready",  32'(bus_ready),  32'd1);
        check("abort_rvalid", 32'(bus_rvalid), 32'd0);
        check("abort_disp",   disp_data,       32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 29; i++) begin
            disp_read(5'(i), d);
            if (i < 10 && d !== 32'h5555_5555) bad++;
            if (i >= 10 && d !== 32'hFFFF_FFFF) bad++;
        end
        check("abort_words_bad", 32'(bad), 32'd0);

        // Sequencer is back in IDLE: a word write is accepted without stalling.
        bus_write(9'h028, 32'h0BAD_F00D, 4'hF);
        check("post_abort_ready", 32'(bus_ready), 32'd1);
        bus_read(9'h028, d, rv);
        check("post_abort_word10", d, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
